// File: rtl/rom_read_arbiter.sv
// Two-master AXI read arbiter in front of the single-burst boot-ROM slave.
// One burst in flight at a time; round-robin on simultaneous requests.
module rom_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int SIZE_W = 3
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // master 0 (instruction fetch)
  input  logic              ARVALID_M0,
  input  logic [ADDR_W-1:0] ARADDR_M0,
  input  logic [ID_W-1:0]   ARID_M0,
  input  logic [LEN_W-1:0]  ARLEN_M0,
  input  logic [SIZE_W-1:0] ARSIZE_M0,
  input  logic [1:0]        ARBURST_M0,
  output logic              ARREADY_M0,
  output logic              RVALID_M0,
  output logic [DATA_W-1:0] RDATA_M0,
  output logic [ID_W-1:0]   RID_M0,
  output logic [1:0]        RRESP_M0,
  output logic              RLAST_M0,
  input  logic              RREADY_M0,
  // master 1 (data access)
  input  logic              ARVALID_M1,
  input  logic [ADDR_W-1:0] ARADDR_M1,
  input  logic [ID_W-1:0]   ARID_M1,
  input  logic [LEN_W-1:0]  ARLEN_M1,
  input  logic [SIZE_W-1:0] ARSIZE_M1,
  input  logic [1:0]        ARBURST_M1,
  output logic              ARREADY_M1,
  output logic              RVALID_M1,
  output logic [DATA_W-1:0] RDATA_M1,
  output logic [ID_W-1:0]   RID_M1,
  output logic [1:0]        RRESP_M1,
  output logic              RLAST_M1,
  input  logic              RREADY_M1,
  // ROM slave port
  output logic              ARVALID_S,
  output logic [ADDR_W-1:0] ARADDR_S,
  output logic [ID_W-1:0]   ARID_S,
  output logic [LEN_W-1:0]  ARLEN_S,
  output logic [SIZE_W-1:0] ARSIZE_S,
  output logic [1:0]        ARBURST_S,
  input  logic              ARREADY_S,
  input  logic              RVALID_S,
  input  logic [DATA_W-1:0] RDATA_S,
  input  logic [ID_W-1:0]   RID_S,
  input  logic [1:0]        RRESP_S,
  input  logic              RLAST_S,
  output logic              RREADY_S
);

  // state | meaning
  // IDLE  | no burst owned; pick owner from requests (prio breaks ties)
  // ADDR  | owner's AR channel wired straight through to the slave
  // DATA  | slave R channel wired straight through to the owner
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   prio_q, prio_d;
  logic   ar_valid_sel, r_ready_sel;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  assign ar_valid_sel = owner_q ? ARVALID_M1 : ARVALID_M0;
  assign r_ready_sel  = owner_q ? RREADY_M1 : RREADY_M0;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    prio_d     = prio_q;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    RVALID_M0  = 1'b0;
    RDATA_M0   = '0;
    RID_M0     = '0;
    RRESP_M0   = '0;
    RLAST_M0   = 1'b0;
    RVALID_M1  = 1'b0;
    RDATA_M1   = '0;
    RID_M1     = '0;
    RRESP_M1   = '0;
    RLAST_M1   = 1'b0;
    ARVALID_S  = 1'b0;
    ARADDR_S   = '0;
    ARID_S     = '0;
    ARLEN_S    = '0;
    ARSIZE_S   = '0;
    ARBURST_S  = '0;
    RREADY_S   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ARVALID_M0 && ARVALID_M1) begin
          owner_d = prio_q;
          state_d = ADDR;
        end else if (ARVALID_M0 || ARVALID_M1) begin
          owner_d = ARVALID_M1;
          state_d = ADDR;
        end
      end

      ADDR: begin
        ARVALID_S = ar_valid_sel;
        if (owner_q) begin
          ARADDR_S   = ARADDR_M1;
          ARID_S     = ARID_M1;
          ARLEN_S    = ARLEN_M1;
          ARSIZE_S   = ARSIZE_M1;
          ARBURST_S  = ARBURST_M1;
          ARREADY_M1 = ARREADY_S;
        end else begin
          ARADDR_S   = ARADDR_M0;
          ARID_S     = ARID_M0;
          ARLEN_S    = ARLEN_M0;
          ARSIZE_S   = ARSIZE_M0;
          ARBURST_S  = ARBURST_M0;
          ARREADY_M0 = ARREADY_S;
        end
        if (ar_valid_sel && ARREADY_S) state_d = DATA;
      end

      DATA: begin
        RREADY_S = r_ready_sel;
        if (owner_q) begin
          RVALID_M1 = RVALID_S;
          RDATA_M1  = RDATA_S;
          RID_M1    = RID_S;
          RRESP_M1  = RRESP_S;
          RLAST_M1  = RLAST_S;
        end else begin
          RVALID_M0 = RVALID_S;
          RDATA_M0  = RDATA_S;
          RID_M0    = RID_S;
          RRESP_M0  = RRESP_S;
          RLAST_M0  = RLAST_S;
        end
        // burst length comes only from RLAST; ARLEN is never counted
        if (RVALID_S && r_ready_sel && RLAST_S) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed self-checking bench for rom_read_arbiter; the bench plays the ROM slave.
module tb_rom_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        ARVALID_M0 = 0, ARVALID_M1 = 0;
  logic [31:0] ARADDR_M0 = 0, ARADDR_M1 = 0;
  logic [3:0]  ARID_M0 = 0, ARID_M1 = 0;
  logic [3:0]  ARLEN_M0 = 0, ARLEN_M1 = 0;
  logic [2:0]  ARSIZE_M0 = 0, ARSIZE_M1 = 0;
  logic [1:0]  ARBURST_M0 = 0, ARBURST_M1 = 0;
  logic        ARREADY_M0, ARREADY_M1;
  logic        RVALID_M0, RVALID_M1;
  logic [31:0] RDATA_M0, RDATA_M1;
  logic [3:0]  RID_M0, RID_M1;
  logic [1:0]  RRESP_M0, RRESP_M1;
  logic        RLAST_M0, RLAST_M1;
  logic        RREADY_M0 = 0, RREADY_M1 = 0;
  logic        ARVALID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARID_S, ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic        ARREADY_S = 0;
  logic        RVALID_S = 0;
  logic [31:0] RDATA_S = 0;
  logic [3:0]  RID_S = 0;
  logic [1:0]  RRESP_S = 0;
  logic        RLAST_S = 0;
  logic        RREADY_S;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  rom_read_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID_M0(ARVALID_M0), .ARADDR_M0(ARADDR_M0), .ARID_M0(ARID_M0),
    .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0), .ARBURST_M0(ARBURST_M0),
    .ARREADY_M0(ARREADY_M0), .RVALID_M0(RVALID_M0), .RDATA_M0(RDATA_M0),
    .RID_M0(RID_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0), .RREADY_M0(RREADY_M0),
    .ARVALID_M1(ARVALID_M1), .ARADDR_M1(ARADDR_M1), .ARID_M1(ARID_M1),
    .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1), .ARBURST_M1(ARBURST_M1),
    .ARREADY_M1(ARREADY_M1), .RVALID_M1(RVALID_M1), .RDATA_M1(RDATA_M1),
    .RID_M1(RID_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1), .RREADY_M1(RREADY_M1),
    .ARVALID_S(ARVALID_S), .ARADDR_S(ARADDR_S), .ARID_S(ARID_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S), .ARREADY_S(ARREADY_S),
    .RVALID_S(RVALID_S), .RDATA_S(RDATA_S), .RID_S(RID_S), .RRESP_S(RRESP_S),
    .RLAST_S(RLAST_S), .RREADY_S(RREADY_S)
  );

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    ARVALID_M0 = 0; ARVALID_M1 = 0; RREADY_M0 = 0; RREADY_M1 = 0;
    ARREADY_S = 0; RVALID_S = 0; RLAST_S = 0; RDATA_S = 0; RID_S = 0; RRESP_S = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    ARESETn = 0;
    @(posedge ACLK);
    @(posedge ACLK);
    #1 ARESETn = 1;
  endtask

  // Slave side of one burst, starting in ADDR: accepts the address, then
  // streams 'beats' beats with both masters ready. Returns in the IDLE cycle.
  task automatic slave_burst(input int beats, output int owner_seen, output int beats_seen);
    ARREADY_S = 1;
    #1;
    owner_seen = ARREADY_M1 ? 1 : (ARREADY_M0 ? 0 : -1);
    step();
    ARREADY_S = 0;
    if (owner_seen == 1) ARVALID_M1 = 0;
    else if (owner_seen == 0) ARVALID_M0 = 0;
    RREADY_M0 = 1; RREADY_M1 = 1;
    beats_seen = 0;
    for (int i = 0; i < beats; i++) begin
      RVALID_S = 1; RDATA_S = 32'hC000 + i; RLAST_S = (i == beats - 1);
      #1;
      if (owner_seen == 1 ? RVALID_M1 : RVALID_M0) beats_seen++;
      step();
    end
    RVALID_S = 0; RLAST_S = 0; RREADY_M0 = 0; RREADY_M1 = 0;
  endtask

  task automatic test_reset();
    ARESETn = 0;
    ARVALID_M0 = 1; ARREADY_S = 1; RVALID_S = 1; RREADY_M0 = 1; RDATA_S = 32'hDEAD;
    #2;
    checks++; if (ARVALID_S !== 1'b0) begin errors++; $display("FAIL rst_arvalid_s got %b exp 0", ARVALID_S); end
    checks++; if (ARREADY_M0 !== 1'b0) begin errors++; $display("FAIL rst_arready_m0 got %b exp 0", ARREADY_M0); end
    checks++; if ({RVALID_M0, RVALID_M1, RREADY_S} !== 3'b000) begin errors++; $display("FAIL rst_r_ctrl got %b exp 000", {RVALID_M0, RVALID_M1, RREADY_S}); end
    checks++; if (RDATA_M0 !== 32'h0 || ARADDR_S !== 32'h0) begin errors++; $display("FAIL rst_payload got rdata %h araddr %h exp 0", RDATA_M0, ARADDR_S); end
    apply_reset();
  endtask

  task automatic test_m0_single();
    int nb = 0;
    logic m1_seen = 0;
    apply_reset();
    ARVALID_M0 = 1; ARADDR_M0 = 32'h100; ARLEN_M0 = 3; ARID_M0 = 2; ARSIZE_M0 = 2; ARBURST_M0 = 1;
    #1;
    checks++; if (ARVALID_S !== 1'b0) begin errors++; $display("FAIL m0_idle_arvalid got %b exp 0", ARVALID_S); end
    step();
    checks++; if (ARVALID_S !== 1'b1) begin errors++; $display("FAIL m0_grant_latency got %b exp 1", ARVALID_S); end
    checks++; if ({ARADDR_S, ARID_S, ARLEN_S, ARSIZE_S, ARBURST_S} !== {32'h100, 4'd2, 4'd3, 3'd2, 2'd1})
      begin errors++; $display("FAIL m0_ar_payload got %h/%h/%h/%h/%h exp 100/2/3/2/1", ARADDR_S, ARID_S, ARLEN_S, ARSIZE_S, ARBURST_S); end
    ARREADY_S = 1;
    #1;
    checks++; if ({ARREADY_M0, ARREADY_M1} !== 2'b10) begin errors++; $display("FAIL m0_arready got %b exp 10", {ARREADY_M0, ARREADY_M1}); end
    step();
    ARVALID_M0 = 0; ARREADY_S = 0; RREADY_M0 = 1;
    for (int i = 0; i < 4; i++) begin
      RVALID_S = 1; RDATA_S = 32'hA000 + i; RID_S = 2; RRESP_S = 2'b10; RLAST_S = (i == 3);
      #1;
      checks++; if ({RDATA_M0, RID_M0, RRESP_M0, RLAST_M0, RREADY_S} !== {32'hA000 + i, 4'd2, 2'b10, (i == 3), 1'b1})
        begin errors++; $display("FAIL m0_beat%0d got %h/%h/%b/%b/%b", i, RDATA_M0, RID_M0, RRESP_M0, RLAST_M0, RREADY_S); end
      if (RVALID_M0) nb++;
      if (RVALID_M1) m1_seen = 1;
      step();
    end
    RLAST_S = 0;
    #1;
    checks++; if (nb !== 4) begin errors++; $display("FAIL m0_beat_count got %0d exp 4", nb); end
    checks++; if (m1_seen !== 1'b0) begin errors++; $display("FAIL m0_m1_rvalid got %b exp 0", m1_seen); end
    checks++; if ({RVALID_M0, RREADY_S} !== 2'b00) begin errors++; $display("FAIL m0_back_idle got %b exp 00", {RVALID_M0, RREADY_S}); end
    RVALID_S = 0; RREADY_M0 = 0;
    ARVALID_M1 = 1; ARADDR_M1 = 32'h40; ARVALID_M0 = 1;
    step();
    checks++; if (ARADDR_S !== 32'h40) begin errors++; $display("FAIL m0_prio_flip got %h exp 40", ARADDR_S); end
    ARVALID_M0 = 0; ARVALID_M1 = 0;
  endtask

  task automatic test_both_after_reset();
    int own, nb;
    apply_reset();
    ARADDR_M0 = 32'h0; ARLEN_M0 = 0; ARADDR_M1 = 32'h40; ARLEN_M1 = 0;
    ARVALID_M0 = 1; ARVALID_M1 = 1;
    step();
    checks++; if (ARADDR_S !== 32'h0) begin errors++; $display("FAIL both_first_addr got %h exp 0", ARADDR_S); end
    ARREADY_S = 1;
    #1;
    checks++; if ({ARREADY_M0, ARREADY_M1} !== 2'b10) begin errors++; $display("FAIL both_arready got %b exp 10", {ARREADY_M0, ARREADY_M1}); end
    step();
    ARVALID_M0 = 0; ARREADY_S = 1; RREADY_M0 = 1;
    RVALID_S = 1; RLAST_S = 1; RDATA_S = 32'h55;
    #1;
    checks++; if ({RVALID_M0, RVALID_M1, ARREADY_M1} !== 3'b100) begin errors++; $display("FAIL both_m0_beat got %b exp 100", {RVALID_M0, RVALID_M1, ARREADY_M1}); end
    step();
    RVALID_S = 0; RLAST_S = 0; RREADY_M0 = 0;
    #1;
    checks++; if ({ARVALID_S, ARREADY_M1} !== 2'b00) begin errors++; $display("FAIL both_gap got %b exp 00", {ARVALID_S, ARREADY_M1}); end
    ARREADY_S = 0;
    step();
    checks++; if ({ARVALID_S, ARADDR_S} !== {1'b1, 32'h40}) begin errors++; $display("FAIL both_m1_grant got %b/%h exp 1/40", ARVALID_S, ARADDR_S); end
    slave_burst(1, own, nb);
    checks++; if (own !== 1 || nb !== 1) begin errors++; $display("FAIL both_m1_burst got owner %0d beats %0d exp 1/1", own, nb); end
  endtask

  task automatic test_back_to_back();
    int own, nb, got;
    ARADDR_M0 = 32'h0; ARADDR_M1 = 32'h40;
    ARVALID_M0 = 1; ARVALID_M1 = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      got = (ARADDR_S == 32'h40) ? 1 : 0;
      slave_burst(2, own, nb);
      checks++; if (got !== k % 2 || own !== k % 2 || nb !== 2)
        begin errors++; $display("FAIL b2b_burst%0d got addr-owner %0d owner %0d beats %0d exp %0d/%0d/2", k, got, own, nb, k % 2, k % 2); end
      if (own == 0) ARVALID_M0 = 1; else ARVALID_M1 = 1;
    end
    ARVALID_M0 = 0; ARVALID_M1 = 0;
  endtask

  task automatic test_addr_stall();
    ARVALID_M0 = 1; ARADDR_M0 = 32'h200; ARLEN_M0 = 1; RREADY_M0 = 1;
    step();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({ARVALID_S, ARREADY_M0, RREADY_S, ARADDR_S} !== {3'b100, 32'h200})
        begin errors++; $display("FAIL stall_cyc%0d got %b%b%b/%h exp 100/200", c, ARVALID_S, ARREADY_M0, RREADY_S, ARADDR_S); end
      step();
    end
    ARREADY_S = 1;
    #1;
    checks++; if ({ARREADY_M0, RREADY_S} !== 2'b10) begin errors++; $display("FAIL stall_release got %b exp 10", {ARREADY_M0, RREADY_S}); end
    step();
    ARVALID_M0 = 0; ARREADY_S = 0; RVALID_S = 1; RDATA_S = 32'hD0;
    #1;
    checks++; if ({RREADY_S, RVALID_M0} !== 2'b11) begin errors++; $display("FAIL stall_data_entry got %b exp 11", {RREADY_S, RVALID_M0}); end
    step();
    RLAST_S = 1;
    step();
    RVALID_S = 0; RLAST_S = 0; RREADY_M0 = 0;
  endtask

  task automatic test_rready_stall();
    logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int k = 0;
    int c = 0;
    ARVALID_M0 = 1; ARLEN_M0 = 2; ARADDR_M0 = 32'h300;
    step();
    ARREADY_S = 1;
    step();
    ARVALID_M0 = 0; ARREADY_S = 0;
    while (k < 3 && c < 10) begin
      RVALID_S = 1; RDATA_S = 32'hB0 + k; RLAST_S = (k == 2);
      RREADY_M0 = (c < 5) ? pat[c] : 1'b1;
      #1;
      checks++; if ({RREADY_S, RDATA_M0} !== {RREADY_M0, 32'hB0 + k})
        begin errors++; $display("FAIL rr_cyc%0d got %b/%h exp %b/%h", c, RREADY_S, RDATA_M0, RREADY_M0, 32'hB0 + k); end
      if (RVALID_M0 && RREADY_M0) k++;
      c++;
      step();
    end
    RVALID_S = 0; RLAST_S = 0;
    #1;
    checks++; if (k !== 3 || c !== 5) begin errors++; $display("FAIL rr_count got beats %0d cycles %0d exp 3/5", k, c); end
    RVALID_S = 1;
    #1;
    checks++; if (RVALID_M0 !== 1'b0) begin errors++; $display("FAIL rr_extra_beat got %b exp 0", RVALID_M0); end
    RVALID_S = 0; RREADY_M0 = 0;
  endtask

  task automatic test_reset_mid_burst();
    int own, nb;
    ARVALID_M1 = 1; ARADDR_M1 = 32'h400; ARLEN_M1 = 3; ARID_M1 = 5;
    step();
    ARREADY_S = 1;
    step();
    ARVALID_M1 = 0; ARREADY_S = 0; RREADY_M1 = 1;
    RVALID_S = 1; RDATA_S = 32'hE0; RID_S = 5;
    step();
    RDATA_S = 32'hE1;
    #1;
    checks++; if ({RVALID_M1, RDATA_M1} !== {1'b1, 32'hE1}) begin errors++; $display("FAIL rm_beat2 got %b/%h exp 1/e1", RVALID_M1, RDATA_M1); end
    ARESETn = 0;
    #1;
    checks++; if ({RVALID_M1, RREADY_S, ARVALID_S, RDATA_M1, RID_M1} !== {3'b000, 32'h0, 4'h0})
      begin errors++; $display("FAIL rm_async got %b%b%b/%h/%h exp 000/0/0", RVALID_M1, RREADY_S, ARVALID_S, RDATA_M1, RID_M1); end
    step();
    ARESETn = 1;
    #1;
    checks++; if ({RVALID_M1, RREADY_S} !== 2'b00) begin errors++; $display("FAIL rm_after_release got %b exp 00", {RVALID_M1, RREADY_S}); end
    RVALID_S = 0; RREADY_M1 = 0;
    ARVALID_M0 = 1; ARADDR_M0 = 32'h500; ARVALID_M1 = 1;
    step();
    checks++; if (ARADDR_S !== 32'h500) begin errors++; $display("FAIL rm_prio_reset got %h exp 500", ARADDR_S); end
    slave_burst(2, own, nb);
    checks++; if (own !== 0 || nb !== 2) begin errors++; $display("FAIL rm_fresh_m0 got owner %0d beats %0d exp 0/2", own, nb); end
    ARVALID_M1 = 0;
  endtask

  initial begin
    test_reset();
    test_m0_single();
    test_both_after_reset();
    test_back_to_back();
    test_addr_stall();
    test_rready_stall();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Two-master AXI read-channel arbiter that shares the single boot-ROM read slave port between the instruction-fetch master (M0) and the data-access master (M1). It sits between the two CPU-side AXI read masters and the ROM wrapper's AR/R slave channels. It grants one complete burst at a time with round-robin fairness and routes the R beats back only to the owning master. Only one transaction is outstanding at any time, matching the single-burst ROM slave.

## Interface
Parameters:
- ADDR_W, 32, AR address width
- DATA_W, 32, R data width
- ID_W, 4, AR/R ID width (passed through unchanged)
- LEN_W, 4, ARLEN width
- SIZE_W, 3, ARSIZE width

Ports (x = 0, 1 for each master port):
- ACLK  in  1  single clock; all logic rising-edge
- ARESETn  in  1  reset, asynchronous, active-low
- ARVALID_Mx  in  1  master x address valid
- ARADDR_Mx / ARID_Mx / ARLEN_Mx / ARSIZE_Mx / ARBURST_Mx  in  ADDR_W / ID_W / LEN_W / SIZE_W / 2  master x AR payload
- ARREADY_Mx  out  1  master x address accepted
- RVALID_Mx  out  1  master x read beat valid
- RDATA_Mx / RID_Mx / RRESP_Mx / RLAST_Mx  out  DATA_W / ID_W / 2 / 1  master x R payload
- RREADY_Mx  in  1  master x beat accept
- ARVALID_S  out  1  to ROM slave
- ARADDR_S / ARID_S / ARLEN_S / ARSIZE_S / ARBURST_S  out  AR payload to slave
- ARREADY_S  in  1  from slave
- RVALID_S / RDATA_S / RID_S / RRESP_S / RLAST_S  in  R channel from slave
- RREADY_S  out  1  to slave

## Operation
- FSM states: IDLE, ADDR, DATA. Registered `owner` (1 bit) and `prio` (1 bit, master with priority on a tie).
- IDLE: no ARREADY, no RVALID to either master, ARVALID_S=0. If exactly one ARVALID_Mx is high, owner<=x. If both are high, owner<=prio. Next state ADDR. With no request, stay in IDLE.
- ADDR: the AR channel of `owner` is connected combinationally to the slave: ARVALID_S=ARVALID_M[owner], payload=M[owner] payload, ARREADY_M[owner]=ARREADY_S. The non-owner's ARREADY is 0. On ARVALID_S&&ARREADY_S, go to DATA.
- DATA: RVALID_M[owner]=RVALID_S, R payload is forwarded to the owner, and RREADY_S=RREADY_M[owner]. The non-owner sees RVALID=0 and RDATA/RID/RRESP/RLAST=0. On RVALID_S&&RREADY_S&&RLAST_S, go to IDLE and set prio<=~owner.
- Outside DATA: RREADY_S=0, and all R outputs to both masters are 0.
- Outside ADDR: ARVALID_S=0, and AR payload to the slave is 0.
- The arbiter never drops or reorders beats. Burst length is governed solely by RLAST_S; ARLEN is not counted.
- A master that deasserts ARVALID while in ADDR violates AXI. This is not handled; the bench must not do it.

## Timing
- Reset (async assert, sync release): state=IDLE, owner=0, prio=0 (M0 favoured first). All outputs 0: ARREADY_Mx, RVALID_Mx, R payloads, ARVALID_S, AR payload, RREADY_S.
- Reset asserted mid-burst: all outputs drop to 0 immediately. After release, the arbiter restarts in IDLE and issues no R beats from the aborted burst.
- Grant latency: ARVALID_Mx high in cycle n (IDLE) gives ARVALID_S=1 in cycle n+1.
- Address handshake is zero added latency in ADDR: ARREADY_Mx follows ARREADY_S in the same cycle.
- R path is fully combinational in DATA, with zero added latency per beat.
- Turnaround: the last-beat handshake in cycle m puts the FSM in IDLE in m+1. The next grant is in m+2, so the minimum gap between bursts is 2 cycles.
- A request arriving while another burst is active waits; its ARVALID must stay high.
- Simultaneous requests in IDLE: the prio master wins. Back-to-back contention therefore alternates M0, M1, M0, and so on.

## Test plan
- Reset, then M0 only: ARADDR=0x100, ARLEN=3, ARID=2. Required: ARVALID_S one cycle later; 4 beats on M0 with RID_M0=2 and RLAST on the 4th; M1 RVALID stays 0; IDLE after the last beat; prio=1.
- Both masters request in the same cycle straight after reset (M0 addr 0x0, M1 addr 0x40, ARLEN=0). Required: M0 served first. M1's ARREADY stays 0 until M0's RLAST handshake, then M1 is granted 2 cycles later.
- Continuous contention for 4 bursts. Required: grant order M0, M1, M0, M1.
- Slave holds ARREADY_S=0 for 3 cycles in ADDR. Required: ARREADY_M0=0 throughout, the payload to the slave is stable, and DATA is entered on the cycle after ARREADY_S=1.
- Owner RREADY toggles 1,0,0,1 during an ARLEN=2 burst. Required: RREADY_S mirrors it, RDATA_M is held on stall cycles, and exactly 3 beats are delivered.
- ARESETn pulsed low during beat 2 of an ARLEN=3 M1 burst. Required: all outputs 0 asynchronously, owner=0, prio=0, and a fresh M0 request afterwards is granted normally.
